// File: rtl/product_deserializer.sv
// ---------------------------------------------------------------------------
// product_deserializer
//   Downstream stage of the serial shift multiplier. Collects the LSB-first
//   product bit stream into a parallel magnitude word, applies the result sign
//   fx^fy (sign-magnitude -> two's complement) and presents the signed product
//   on a valid/ready handshake. Frame boundaries are checked against z_done.
//
//   Parameters
//     PROD_W       magnitude bits per product frame (must be >= 2)
//
//   Ports
//     clk          system clock, rising edge
//     rst          asynchronous active-low reset
//     z_serial     product bit, LSB first
//     z_bit_valid  z_serial is valid this cycle
//     z_done       last bit of a frame, qualified by z_bit_valid
//     fx, fy       operand signs, sampled with the first bit of a frame
//     p_data       signed two's-complement product, PROD_W+1 bits
//     p_valid      p_data holds a complete product
//     p_ready      consumer accepts p_data when p_valid && p_ready
//     busy         a frame is being collected
//     frame_err    sticky framing error (early/missing z_done, dropped bit)
//     err_clr      synchronous clear of frame_err
// ---------------------------------------------------------------------------
module product_deserializer #(
    parameter int unsigned PROD_W = 23
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            z_serial,
    input  logic            z_bit_valid,
    input  logic            z_done,
    input  logic            fx,
    input  logic            fy,
    output logic [PROD_W:0] p_data,
    output logic            p_valid,
    input  logic            p_ready,
    output logic            busy,
    output logic            frame_err,
    input  logic            err_clr
);

    localparam int unsigned CNT_W = (PROD_W > 1) ? $clog2(PROD_W) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        HOLD
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [PROD_W-1:0]   shreg;
    logic                sign;

    logic                last_bit;
    logic                hold_xfer;
    logic                start_ok;
    logic                err_set;
    logic [PROD_W-1:0]   word_next;
    logic [PROD_W:0]     mag_next;
    logic [PROD_W:0]     prod_next;

    always_comb begin
        last_bit  = (cnt == CNT_W'(PROD_W - 1));
        hold_xfer = (state == HOLD) && p_valid && p_ready;

        // A new frame starts from IDLE, or from HOLD when the pending word is
        // handed off in the same cycle (back-to-back frames, no bubble).
        // A first bit that already carries z_done is a framing error and does
        // not start a frame.
        start_ok  = z_bit_valid && !z_done && ((state == IDLE) || hold_xfer);

        // Upper bits of shreg are cleared when a frame starts, so OR-ing the
        // incoming bit in at position cnt builds the word LSB first.
        word_next = shreg | (PROD_W'(z_serial) << cnt);
        mag_next  = {1'b0, word_next};
        prod_next = sign ? ((~mag_next) + {{PROD_W{1'b0}}, 1'b1}) : mag_next;

        err_set = 1'b0;
        case (state)
            IDLE:    err_set = z_bit_valid && z_done;
            SHIFT:   err_set = z_bit_valid && (last_bit != z_done);
            HOLD:    err_set = z_bit_valid && (!hold_xfer || z_done);
            default: err_set = 1'b0;
        endcase

        busy = (state == SHIFT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            shreg     <= '0;
            sign      <= 1'b0;
            p_data    <= '0;
            p_valid   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            // Setting wins over a simultaneous clear.
            if (err_set) begin
                frame_err <= 1'b1;
            end else if (err_clr) begin
                frame_err <= 1'b0;
            end

            case (state)
                IDLE: begin
                    // Frame start handled below.
                end
                SHIFT: begin
                    if (z_bit_valid) begin
                        if (last_bit) begin
                            // Word is output even if z_done was missing.
                            p_data  <= prod_next;
                            p_valid <= 1'b1;
                            cnt     <= '0;
                            state   <= HOLD;
                        end else if (z_done) begin
                            // Early z_done: discard the partial word.
                            cnt   <= '0;
                            state <= IDLE;
                        end else begin
                            shreg <= word_next;
                            cnt   <= cnt + CNT_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (hold_xfer) begin
                        p_valid <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            // Shared frame-start action for IDLE and HOLD-with-transfer; placed
            // last so its state update overrides the HOLD->IDLE move above.
            if (start_ok) begin
                shreg <= PROD_W'(z_serial);
                sign  <= fx ^ fy;
                cnt   <= CNT_W'(1);
                state <= SHIFT;
            end
        end
    end

endmodule

// File: tb/tb_product_deserializer.sv
module tb_product_deserializer;

    localparam int PW = 23;

    logic        clk;
    logic        rst;
    logic        z_serial;
    logic        z_bit_valid;
    logic        z_done;
    logic        fx;
    logic        fy;
    logic [PW:0] p_data;
    logic        p_valid;
    logic        p_ready;
    logic        busy;
    logic        frame_err;
    logic        err_clr;

    product_deserializer #(.PROD_W(PW)) dut (
        .clk        (clk),
        .rst        (rst),
        .z_serial   (z_serial),
        .z_bit_valid(z_bit_valid),
        .z_done     (z_done),
        .fx         (fx),
        .fy         (fy),
        .p_data     (p_data),
        .p_valid    (p_valid),
        .p_ready    (p_ready),
        .busy       (busy),
        .frame_err  (frame_err),
        .err_clr    (err_clr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        vfx;
        logic        vfy;
        logic [22:0] mag;
        int          done_pos;   // bit carrying z_done; -1 = never
        logic [23:0] exp_data;
        logic        exp_valid;
        logic        exp_err;
    } vec_t;

    vec_t vecs[8];

    // Products observed on completed handshakes during the streaming phase.
    logic        mon_en = 1'b0;
    logic [23:0] obs_q[$];

    always @(negedge clk) begin
        if (mon_en && p_valid && p_ready) obs_q.push_back(p_data);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: signed product from magnitude and operand signs.
    function automatic logic [23:0] model(input logic [22:0] mag, input logic sfx, input logic sfy);
        logic [23:0] m24;
        m24 = {1'b0, mag};
        return (sfx ^ sfy) ? (24'd0 - m24) : m24;
    endfunction

    task automatic send_bits(input logic [22:0] mag, input logic sfx, input logic sfy,
                             input int first, input int last, input int done_pos,
                             input int max_gap);
        int g;
        for (int i = first; i <= last; i++) begin
            g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            repeat (g) begin
                @(posedge clk);
                #1;
            end
            fx          = sfx;
            fy          = sfy;
            z_serial    = mag[i];
            z_bit_valid = 1'b1;
            z_done      = (i == done_pos);
            @(posedge clk);
            #1;
            z_bit_valid = 1'b0;
            z_done      = 1'b0;
            z_serial    = 1'b0;
        end
    endtask

    task automatic xfer();
        p_ready = 1'b1;
        @(posedge clk);
        #1;
        p_ready = 1'b0;
    endtask

    task automatic clear_err();
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
    endtask

    initial begin
        logic [22:0] m1, m2;
        logic [23:0] e1, e2;
        logic        s1x, s1y, s2x, s2y;
        logic [23:0] exp_arr[$];
        int          last;
        int          nfr;

        z_serial = 0; z_bit_valid = 0; z_done = 0; fx = 0; fy = 0;
        p_ready = 0; err_clr = 0; rst = 1'b1;

        vecs[0] = '{1'b1, 1'b1, 23'h7FF800, 22, 24'h7FF800, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 23'h000001, 22, 24'hFFFFFF, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 23'h000000, 22, 24'h000000, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 23'h7FFFFF, 22, 24'h7FFFFF, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 23'h7FFFFF, 22, 24'h800001, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 23'h123456, 15, 24'h000000, 1'b0, 1'b1};
        vecs[6] = '{1'b0, 1'b1, 23'h000ABC, -1, 24'hFFF544, 1'b1, 1'b1};
        vecs[7] = '{1'b1, 1'b1, 23'h2AAAAA, 22, 24'h2AAAAA, 1'b1, 1'b0};

        // Reset state
        #1 rst = 1'b0;
        #1;
        check("rst_p_data", 32'(p_data), 32'h0);
        check("rst_p_valid", 32'(p_valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_frame_err", 32'(frame_err), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Table-driven frames
        for (int v = 0; v < 8; v++) begin
            clear_err();
            last = (vecs[v].done_pos >= 0 && vecs[v].done_pos < 22) ? vecs[v].done_pos : 22;
            send_bits(vecs[v].mag, vecs[v].vfx, vecs[v].vfy, 0, last, vecs[v].done_pos, 1);
            check($sformatf("vec%0d_p_valid", v), 32'(p_valid), 32'(vecs[v].exp_valid));
            if (vecs[v].exp_valid)
                check($sformatf("vec%0d_p_data", v), 32'(p_data), 32'(vecs[v].exp_data));
            check($sformatf("vec%0d_frame_err", v), 32'(frame_err), 32'(vecs[v].exp_err));
            check($sformatf("vec%0d_busy", v), 32'(busy), 32'h0);
            if (vecs[v].exp_valid) begin
                xfer();
                check($sformatf("vec%0d_after_xfer_valid", v), 32'(p_valid), 32'h0);
            end
        end

        // Reset in the middle of a frame, with non-zero outputs beforehand
        send_bits(23'h00000F, 1'b0, 1'b0, 0, 3, 3, 0);
        check("pre_rst_err", 32'(frame_err), 32'h1);
        send_bits(23'h155555, 1'b1, 1'b0, 0, 9, 99, 0);
        check("mid_shift_busy", 32'(busy), 32'h1);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 32'h0);
        check("mid_rst_p_data", 32'(p_data), 32'h0);
        check("mid_rst_p_valid", 32'(p_valid), 32'h0);
        check("mid_rst_frame_err", 32'(frame_err), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        send_bits(23'h3C0F0F, 1'b1, 1'b0, 0, 22, 22, 0);
        check("post_rst_valid", 32'(p_valid), 32'h1);
        check("post_rst_data", 32'(p_data), 32'(model(23'h3C0F0F, 1'b1, 1'b0)));
        check("post_rst_err", 32'(frame_err), 32'h0);
        xfer();

        // HOLD back-pressure with dropped bits, then transfer with a coincident start
        m1 = 23'h0ABCDE; s1x = 1'b0; s1y = 1'b1; e1 = model(m1, s1x, s1y);
        m2 = 23'h654321; s2x = 1'b1; s2y = 1'b0; e2 = model(m2, s2x, s2y);
        send_bits(m1, s1x, s1y, 0, 22, 22, 0);
        check("hold_valid", 32'(p_valid), 32'h1);
        check("hold_data", 32'(p_data), 32'(e1));
        for (int k = 0; k < 5; k++) begin
            z_bit_valid = 1'b1;
            z_serial    = 1'($urandom);
            @(posedge clk);
            #1;
            z_bit_valid = 1'b0;
            check($sformatf("hold_stable%0d", k), 32'(p_data), 32'(e1));
        end
        check("hold_drop_err", 32'(frame_err), 32'h1);
        clear_err();
        check("hold_err_clr", 32'(frame_err), 32'h0);
        check("hold_still_valid", 32'(p_valid), 32'h1);
        fx = s2x; fy = s2y; z_serial = m2[0]; z_bit_valid = 1'b1; p_ready = 1'b1;
        @(posedge clk);
        #1;
        z_bit_valid = 1'b0; p_ready = 1'b0; z_serial = 1'b0;
        check("b2b_valid_low", 32'(p_valid), 32'h0);
        check("b2b_busy", 32'(busy), 32'h1);
        send_bits(m2, s2x, s2y, 1, 22, 22, 1);
        check("b2b_data", 32'(p_data), 32'(e2));
        check("b2b_valid", 32'(p_valid), 32'h1);
        check("b2b_err", 32'(frame_err), 32'h0);
        xfer();

        // Set and clear in the same cycle: set wins
        err_clr = 1'b1;
        send_bits(23'h1, 1'b0, 1'b0, 0, 0, 0, 0);
        err_clr = 1'b0;
        check("set_beats_clr", 32'(frame_err), 32'h1);
        clear_err();

        // Randomised back-to-back stream with p_ready tied high
        p_ready = 1'b1;
        mon_en  = 1'b1;
        nfr     = 12;
        for (int f = 0; f < nfr; f++) begin
            logic [22:0] rm;
            logic        rx, ry;
            case (f % 6)
                0:       rm = 23'h0;
                1:       rm = 23'h7FFFFF;
                default: rm = 23'($urandom);
            endcase
            rx = 1'($urandom);
            ry = 1'($urandom);
            exp_arr.push_back(model(rm, rx, ry));
            send_bits(rm, rx, ry, 0, 22, 22, (f % 3 == 0) ? 0 : 2);
        end
        for (int k = 0; k < 20 && obs_q.size() < nfr; k++) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        mon_en  = 1'b0;
        p_ready = 1'b0;
        check("stream_count", 32'(obs_q.size()), 32'(nfr));
        for (int f = 0; f < nfr && f < obs_q.size(); f++)
            check($sformatf("stream%0d_data", f), 32'(obs_q[f]), 32'(exp_arr[f]));
        check("stream_err", 32'(frame_err), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
